cam_capture: RTL



---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_sync_edge.sv | 35 +++
 rtl/cam_capture.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera capture front end.
//   state_t      : capture FSM states (WAIT_FRAME, ACTIVE)
//   phase_t      : byte phase within an RGB565 pixel (HI first, then LO)
//   SYNC_STAGES  : depth of the input synchronizers
//   R/G/B_*      : RGB565 field positions in the assembled pixel
//   sat_inc10    : 10-bit increment that saturates at 1023
package cam_pkg;
  typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_t;
  typedef enum logic {HI = 1'b0, LO = 1'b1} phase_t;

  localparam int SYNC_STAGES = 2;

  localparam int R_MSB = 15, R_LSB = 11;
  localparam int G_MSB = 10, G_LSB = 5;
  localparam int B_MSB = 4,  B_LSB = 0;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: W-bit synchronizer (SYNC_STAGES flops) plus one extra flop
// for rise/fall detection on the synchronized value.
//   clk, reset : system clock, synchronous active-high reset
//   d          : asynchronous input
//   q          : synchronized value (last synchronizer stage)
//   rise, fall : per-bit edge pulses, q & ~prev / ~q & prev
module cam_sync_edge
  import cam_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [SYNC_STAGES-1:0][W-1:0] sync;
  logic [W-1:0]                  prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/cam_capture.sv
// cam_capture: camera front end. Generates xclk, samples pclk/href/vref/data
// in the clk domain, assembles byte pairs into RGB565 pixels and strobes them
// out with a linear frame-buffer address.
//   clk, reset      : system clock, synchronous active-high reset
//   pclk/href/vref  : camera timing inputs (asynchronous)
//   digital[7:0]    : camera data bus
//   xclk            : camera master clock, period 2*XCLK_DIV clk
//   pixel[15:0]     : last assembled pixel {first byte, second byte}
//   pixel_valid     : one-clk write strobe for pixel/waddr
//   waddr           : frame-buffer address of the strobed pixel
//   x, y            : full-resolution pixel / line position
//   frame_done      : one-clk pulse on vref rise while capturing
//   line_err        : sticky, a line ended with x != WIDTH
// Build option CAM_DECIMATE_EN: strobe only even x / even y pixels (2x
// decimation); waddr then counts kept pixels only.
module cam_capture
  import cam_pkg::*;
#(
  parameter int XCLK_DIV = 2,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pclk,
  input  logic              href,
  input  logic              vref,
  input  logic [7:0]        digital,
  output logic              xclk,
  output logic [15:0]       pixel,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] waddr,
  output logic [9:0]        x,
  output logic [9:0]        y,
  output logic              frame_done,
  output logic              line_err
);
  localparam int         CW  = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;
  localparam logic [9:0] W10 = 10'(WIDTH);
  localparam logic [9:0] H10 = 10'(HEIGHT);

  // xclk divider, free-running in every state
  logic [CW-1:0] xcnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      xcnt <= '0;
      xclk <= 1'b0;
    end else if (xcnt == CW'(XCLK_DIV - 1)) begin
      xcnt <= '0;
      xclk <= ~xclk;
    end else begin
      xcnt <= xcnt + 1'b1;
    end
  end

  // input synchronizers
  logic pclk_rise, pclk_q_unused, pclk_fall_unused;
  logic href_q, href_rise, href_fall;
  logic vref_rise, vref_fall, vref_q_unused;
  logic [7:0] data_q, data_rise_unused, data_fall_unused;

  cam_sync_edge #(.W(1)) u_pclk (.clk(clk), .reset(reset), .d(pclk),
    .q(pclk_q_unused), .rise(pclk_rise), .fall(pclk_fall_unused));
  cam_sync_edge #(.W(1)) u_href (.clk(clk), .reset(reset), .d(href),
    .q(href_q), .rise(href_rise), .fall(href_fall));
  cam_sync_edge #(.W(1)) u_vref (.clk(clk), .reset(reset), .d(vref),
    .q(vref_q_unused), .rise(vref_rise), .fall(vref_fall));
  cam_sync_edge #(.W(8)) u_data (.clk(clk), .reset(reset), .d(digital),
    .q(data_q), .rise(data_rise_unused), .fall(data_fall_unused));

  // Event stage: edges, href level and data are registered together so the
  // FSM sees them aligned and its outputs land 4 clk after the pin edge.
  logic       pclk_ev, href_rise_ev, href_fall_ev, href_lvl_ev;
  logic       vref_rise_ev, vref_fall_ev;
  logic [7:0] data_ev;
  always_ff @(posedge clk) begin
    if (reset) begin
      {pclk_ev, href_rise_ev, href_fall_ev, href_lvl_ev} <= '0;
      {vref_rise_ev, vref_fall_ev}                       <= '0;
      data_ev                                            <= '0;
    end else begin
      pclk_ev      <= pclk_rise;
      href_rise_ev <= href_rise;
      href_fall_ev <= href_fall;
      href_lvl_ev  <= href_q;
      vref_rise_ev <= vref_rise;
      vref_fall_ev <= vref_fall;
      data_ev      <= data_q;
    end
  end

  // capture FSM
  state_t            state, state_n;
  phase_t            phase, phase_n;
  logic [7:0]        hi, hi_n;
  logic [ADDR_W-1:0] wptr, wptr_n, waddr_n;
  logic [15:0]       pixel_n;
  logic [9:0]        x_n, y_n;
  logic              pv_n, fd_n, le_n, keep;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_FRAME;
      phase       <= HI;
      hi          <= '0;
      wptr        <= '0;
      waddr       <= '0;
      pixel       <= '0;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      hi          <= hi_n;
      wptr        <= wptr_n;
      waddr       <= waddr_n;
      pixel       <= pixel_n;
      x           <= x_n;
      y           <= y_n;
      pixel_valid <= pv_n;
      frame_done  <= fd_n;
      line_err    <= le_n;
    end
  end

  // Within ACTIVE the events are applied in order: href rise, pclk, href
  // fall, vref rise -- each step sees the results of the previous ones.
  always_comb begin
    state_n = state;
    phase_n = phase;
    hi_n    = hi;
    wptr_n  = wptr;
    waddr_n = waddr;
    pixel_n = pixel;
    x_n     = x;
    y_n     = y;
    pv_n    = 1'b0;
    fd_n    = 1'b0;
    le_n    = line_err;
    keep    = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (vref_fall_ev) begin
          y_n     = '0;
          wptr_n  = '0;
          waddr_n = '0;
          phase_n = HI;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (href_rise_ev) begin
          x_n     = '0;
          phase_n = HI;
        end
        // href_fall_ev still counts as "href high" so a pclk edge landing
        // with the fall is taken before the line is closed
        if (pclk_ev && (href_lvl_ev || href_fall_ev)) begin
          if (phase_n == HI) begin
            hi_n    = data_ev;
            phase_n = LO;
          end else begin
            pixel_n[R_MSB:R_LSB] = hi[7:3];
            pixel_n[G_MSB:G_LSB] = {hi[2:0], data_ev[7:5]};
            pixel_n[B_MSB:B_LSB] = data_ev[4:0];
            phase_n = HI;
            keep    = (x_n < W10) && (y_n < H10);
`ifdef CAM_DECIMATE_EN
            keep    = keep && !x_n[0] && !y_n[0];
`endif
            if (keep) begin
              pv_n    = 1'b1;
              waddr_n = wptr_n;
              wptr_n  = wptr_n + 1'b1;
            end
            x_n = sat_inc10(x_n);
          end
        end
        if (href_fall_ev) begin
          if (x_n != W10) le_n = 1'b1;
          if (x_n != '0)  y_n  = sat_inc10(y_n);
          phase_n = HI;  // drops any half pixel
        end
        if (vref_rise_ev) begin
          fd_n    = 1'b1;
          state_n = WAIT_FRAME;
        end
      end
      default: state_n = WAIT_FRAME;
    endcase
  end
endmodule
